// File: rtl/cubehash_tx_pkg.sv
// Shared types and constants for the CubeHash message transmitter.
//   tx_state_t        : transmitter FSM state encoding
//   PAD_FIRST/PAD_FILL: padding bytes (first pad byte, fill bytes)
//   DEF_*             : default block size and timing
//   max3()            : helper for sizing the shared timer
package cubehash_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    LOAD,
    FETCH,
    TAIL
  } tx_state_t;

  localparam logic [7:0] PAD_FIRST = 8'h80;
  localparam logic [7:0] PAD_FILL  = 8'h00;

  localparam int DEF_BLOCK_BYTES = 32;
  localparam int DEF_LOAD_CYCLES = 10;
  localparam int DEF_GAP_CYCLES  = 12;
  localparam int DEF_TAIL_CYCLES = 250;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cubehash_tx_timer.sv
// Loadable down-counter used for the GAP, LOAD and TAIL durations.
//   clk      : system clock
//   rst_p    : asynchronous active-high reset (count -> 0)
//   load_en  : reload the counter with load_val this cycle
//   load_val : reload value (duration - 1)
//   zero     : counter has reached zero
module cubehash_tx_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_p,
  input  logic         load_en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      count <= '0;
    end else if (load_en) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cubehash_msg_tx.sv
// Byte-serial message transmitter for the cubehash_exp message-load port.
// Takes message bytes from a valid/ready source, appends CubeHash padding
// (0x80 then zeros to the block boundary) and presents each byte with the
// core's level-held load strobe and inter-byte gap timing.
//   clk, rst_p        : clock, asynchronous active-high reset
//   s_data/s_valid/
//   s_last/s_ready    : upstream byte stream (s_last marks final byte)
//   abort             : synchronous abort of the message in progress
//   part_msg/load     : byte and load strobe to the core
//   start/in_en       : hash-session active / input enable to the core
//   busy              : message in progress
//   done              : one-cycle pulse at session end
//
// state | meaning
// IDLE  | waiting for the first byte of a message
// GAP   | load low, part_msg stable, waiting out the inter-byte gap
// LOAD  | load high for the byte on part_msg
// FETCH | waiting for the next upstream data byte
// TAIL  | all bytes loaded, start held while the core finishes
module cubehash_msg_tx
  import cubehash_tx_pkg::*;
#(
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter int LOAD_CYCLES = DEF_LOAD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int TAIL_CYCLES = DEF_TAIL_CYCLES
) (
  input  logic       clk,
  input  logic       rst_p,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  input  logic       abort,
  output logic [7:0] part_msg,
  output logic       load,
  output logic       start,
  output logic       in_en,
  output logic       busy,
  output logic       done
);

  localparam int PW = $clog2(BLOCK_BYTES);
  localparam int TW = $clog2(max3(LOAD_CYCLES, GAP_CYCLES, TAIL_CYCLES) + 1);

  tx_state_t       state;
  logic [PW-1:0]   pos;
  logic [PW-1:0]   pos_inc;
  logic            last_q;
  logic            pad_q;
  logic            accept;
  logic            kill;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_zero;

  assign accept  = s_valid && s_ready && ((state == IDLE) || (state == FETCH));
  assign kill    = abort && (state != IDLE);
  assign pos_inc = pos + PW'(1);

  // Timer reload on every state change. The gap after a FETCH is one
  // cycle shorter because the FETCH cycle itself already had load low,
  // so an unstalled byte sees exactly GAP_CYCLES of load low.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (kill) begin
      tmr_load = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tmr_load = accept;
          tmr_val  = TW'(GAP_CYCLES - 1);
        end
        FETCH: begin
          tmr_load = accept;
          tmr_val  = TW'(GAP_CYCLES - 2);
        end
        GAP: begin
          tmr_load = tmr_zero;
          tmr_val  = TW'(LOAD_CYCLES - 1);
        end
        LOAD: begin
          tmr_load = tmr_zero;
          tmr_val  = (pad_q && (pos_inc == '0)) ? TW'(TAIL_CYCLES - 1)
                                                : TW'(GAP_CYCLES - 1);
        end
        default: begin
          tmr_load = 1'b0;
        end
      endcase
    end
  end

  cubehash_tx_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_p    (rst_p),
    .load_en  (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state    <= IDLE;
      part_msg <= 8'h00;
      load     <= 1'b0;
      start    <= 1'b0;
      in_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      s_ready  <= 1'b0;
      pos      <= '0;
      last_q   <= 1'b0;
      pad_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state    <= IDLE;
        part_msg <= 8'h00;
        load     <= 1'b0;
        start    <= 1'b0;
        in_en    <= 1'b0;
        busy     <= 1'b0;
        s_ready  <= 1'b0;
        pos      <= '0;
        last_q   <= 1'b0;
        pad_q    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            pos <= '0;
            if (accept) begin
              part_msg <= s_data;
              last_q   <= s_last;
              pad_q    <= 1'b0;
              start    <= 1'b1;
              in_en    <= 1'b1;
              busy     <= 1'b1;
              s_ready  <= 1'b0;
              state    <= GAP;
            end else begin
              // ready rises one cycle after entering IDLE, so a new
              // message is never taken in the same cycle as done
              s_ready <= 1'b1;
            end
          end
          GAP: begin
            if (tmr_zero) begin
              load  <= 1'b1;
              state <= LOAD;
            end
          end
          LOAD: begin
            if (tmr_zero) begin
              load <= 1'b0;
              pos  <= pos_inc;
              if (!pad_q && !last_q) begin
                s_ready <= 1'b1;
                state   <= FETCH;
              end else if (!pad_q) begin
                part_msg <= PAD_FIRST;
                pad_q    <= 1'b1;
                state    <= GAP;
              end else if (pos_inc != '0) begin
                part_msg <= PAD_FILL;
                state    <= GAP;
              end else begin
                state <= TAIL;
              end
            end
          end
          FETCH: begin
            if (accept) begin
              part_msg <= s_data;
              last_q   <= s_last;
              s_ready  <= 1'b0;
              state    <= GAP;
            end
          end
          TAIL: begin
            if (tmr_zero) begin
              start <= 1'b0;
              in_en <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cubehash_msg_tx.sv
// Self-checking bench for cubehash_msg_tx: a negedge monitor records every
// loaded byte, load-high lengths, load-low gaps and tail lengths; each test
// task compares those against a padded-message model built from queues.
module tb_cubehash_msg_tx;

  localparam int BB = 32;
  localparam int LC = 10;
  localparam int GC = 12;
  localparam int TC = 250;

  logic       clk = 1'b0;
  logic       rst_p = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       abort = 1'b0;
  logic       s_ready, load, start, in_en, busy, done;
  logic [7:0] part_msg;

  int n_cmp = 0;
  int n_err = 0;

  cubehash_msg_tx #(
    .BLOCK_BYTES(BB), .LOAD_CYCLES(LC), .GAP_CYCLES(GC), .TAIL_CYCLES(TC)
  ) dut (
    .clk(clk), .rst_p(rst_p), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .abort(abort),
    .part_msg(part_msg), .load(load), .start(start), .in_en(in_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] cap_q[$];
  int         hi_q[$];
  int         gap_q[$];
  int         tail_q[$];
  logic       prev_load = 1'b0;
  logic       prev_start = 1'b0;
  logic [7:0] held = 8'h00;
  int hi_cnt = 0, lo_cnt = 0, tail_run = 0;
  int done_cnt = 0, done_cyc = 0, pm_viol = 0, fetch_viol = 0;

  always @(negedge clk) begin
    prev_load  <= load;
    prev_start <= start;
    if (load === 1'b1 && prev_load !== 1'b1) begin
      cap_q.push_back(part_msg);
      gap_q.push_back(lo_cnt);
      held   <= part_msg;
      hi_cnt <= 1;
    end else if (load === 1'b1) begin
      hi_cnt <= hi_cnt + 1;
      if (part_msg !== held) pm_viol <= pm_viol + 1;
    end
    if (load !== 1'b1 && prev_load === 1'b1) begin
      hi_q.push_back(hi_cnt);
      lo_cnt   <= 1;
      tail_run <= (start === 1'b1) ? 1 : 0;
    end else if (load !== 1'b1) begin
      lo_cnt <= lo_cnt + 1;
      if (start === 1'b1) tail_run <= tail_run + 1;
    end
    if (prev_start === 1'b1 && start !== 1'b1) tail_q.push_back(tail_run);
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (s_ready === 1'b1 && load === 1'b1) fetch_viol <= fetch_viol + 1;
  end

  logic [7:0] msg [0:127];

  task automatic drive_msg(input int len, input int n_send, input int stall_at,
                           input int stall_len, output bit tmo, output bit acc_ok);
    bit rdy;
    int t;
    tmo = 1'b0;
    acc_ok = 1'b0;
    for (int i = 0; i < n_send; i++) begin
      s_data = msg[i];
      s_last = (i == len - 1);
      s_valid = 1'b1;
      t = 0;
      do begin
        rdy = (s_ready === 1'b1);
        @(posedge clk); #1;
        t++;
      end while (!rdy && t < 3000);
      if (!rdy) begin
        tmo = 1'b1;
        break;
      end
      if (i == 0) acc_ok = (start === 1'b1) && (in_en === 1'b1) && (busy === 1'b1);
      if (i == stall_at) begin
        s_valid = 1'b0;
        repeat (stall_len) @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_done(output bit tmo);
    int t;
    tmo = 1'b1;
    t = 0;
    while (t < 4000) begin
      if (done === 1'b1) begin
        tmo = 1'b0;
        break;
      end
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({load, start, in_en, busy, done, s_ready} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 000000", {load, start, in_en, busy, done, s_ready});
    end
    n_cmp++;
    if (part_msg !== 8'h00) begin
      n_err++;
      $display("FAIL reset_part_msg: got %h expected 00", part_msg);
    end
    rst_p = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_ready: got s_ready=%b busy=%b expected 1 0", s_ready, busy);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_abort_ignored: got s_ready=%b busy=%b expected 1 0", s_ready, busy);
    end
  endtask

  task automatic test_padding();
    int lens[3] = '{3, 31, 32};
    for (int m = 0; m < 7; m++) begin
      int len, cb, hb, gb, tb, db, pv, fv, nbad, tl;
      bit tmo1, tmo2, acc_ok;
      logic [7:0] exp_q[$];
      len = (m < 3) ? lens[m] : int'($urandom_range(1, 70));
      for (int i = 0; i < len; i++) msg[i] = (m == 0) ? 8'h00 : 8'($urandom);
      exp_q.delete();
      for (int i = 0; i < len; i++) exp_q.push_back(msg[i]);
      exp_q.push_back(8'h80);
      while (exp_q.size() % BB != 0) exp_q.push_back(8'h00);
      cb = cap_q.size(); hb = hi_q.size(); gb = gap_q.size(); tb = tail_q.size();
      db = done_cnt; pv = pm_viol; fv = fetch_viol;
      drive_msg(len, len, -1, 0, tmo1, acc_ok);
      wait_done(tmo2);
      n_cmp++;
      if (tmo1 || tmo2) begin
        n_err++;
        $display("FAIL pad_timeout len=%0d: got accept_tmo=%0d done_tmo=%0d expected 0 0", len, tmo1, tmo2);
      end
      n_cmp++;
      if (!acc_ok) begin
        n_err++;
        $display("FAIL pad_start_at_accept len=%0d: got 0 expected 1", len);
      end
      n_cmp++;
      if (cap_q.size() - cb != (len / BB + 1) * BB) begin
        n_err++;
        $display("FAIL pad_count len=%0d: got %0d expected %0d", len, cap_q.size() - cb, (len / BB + 1) * BB);
      end
      nbad = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
        logic [7:0] got;
        got = (cb + k < cap_q.size()) ? cap_q[cb + k] : 8'hxx;
        n_cmp++;
        if (got !== exp_q[k]) begin
          n_err++;
          if (nbad < 4) $display("FAIL pad_byte len=%0d idx=%0d: got %h expected %h", len, k, got, exp_q[k]);
          nbad++;
        end
      end
      for (int k = hb; k < hi_q.size(); k++) begin
        n_cmp++;
        if (hi_q[k] != LC) begin
          n_err++;
          $display("FAIL pad_load_len len=%0d idx=%0d: got %0d expected %0d", len, k - hb, hi_q[k], LC);
        end
      end
      for (int k = gb + 1; k < gap_q.size(); k++) begin
        n_cmp++;
        if (gap_q[k] != GC) begin
          n_err++;
          $display("FAIL pad_gap_len len=%0d idx=%0d: got %0d expected %0d", len, k - gb, gap_q[k], GC);
        end
      end
      tl = (tail_q.size() > tb) ? tail_q[tb] : -1;
      n_cmp++;
      if (tl != TC) begin
        n_err++;
        $display("FAIL pad_tail len=%0d: got %0d expected %0d", len, tl, TC);
      end
      n_cmp++;
      if (done_cnt - db != 1) begin
        n_err++;
        $display("FAIL pad_done_pulses len=%0d: got %0d expected 1", len, done_cnt - db);
      end
      n_cmp++;
      if (pm_viol != pv || fetch_viol != fv) begin
        n_err++;
        $display("FAIL pad_stability len=%0d: got %0d %0d violations expected 0", len, pm_viol - pv, fetch_viol - fv);
      end
    end
  endtask

  task automatic test_backpressure();
    int cb, gb, db, fv, nbad, g3;
    bit tmo1, tmo2, acc_ok;
    logic [7:0] exp_q[$];
    for (int i = 0; i < 5; i++) msg[i] = 8'($urandom);
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(msg[i]);
    exp_q.push_back(8'h80);
    while (exp_q.size() % BB != 0) exp_q.push_back(8'h00);
    cb = cap_q.size(); gb = gap_q.size(); db = done_cnt; fv = fetch_viol;
    drive_msg(5, 5, 1, 50, tmo1, acc_ok);
    wait_done(tmo2);
    n_cmp++;
    if (tmo1 || tmo2) begin
      n_err++;
      $display("FAIL bp_timeout: got %0d %0d expected 0 0", tmo1, tmo2);
    end
    n_cmp++;
    if (cap_q.size() - cb != BB) begin
      n_err++;
      $display("FAIL bp_count: got %0d expected %0d", cap_q.size() - cb, BB);
    end
    nbad = 0;
    for (int k = 0; k < BB; k++) begin
      logic [7:0] got;
      got = (cb + k < cap_q.size()) ? cap_q[cb + k] : 8'hxx;
      if (got !== exp_q[k]) nbad++;
    end
    n_cmp++;
    if (nbad != 0) begin
      n_err++;
      $display("FAIL bp_bytes: got %0d wrong bytes expected 0", nbad);
    end
    n_cmp++;
    if (fetch_viol != fv) begin
      n_err++;
      $display("FAIL bp_load_in_stall: got %0d cycles expected 0", fetch_viol - fv);
    end
    g3 = (gap_q.size() > gb + 2) ? gap_q[gb + 2] : -1;
    n_cmp++;
    if (g3 <= GC) begin
      n_err++;
      $display("FAIL bp_stall_gap: got %0d expected more than %0d", g3, GC);
    end
    for (int k = gb + 3; k < gap_q.size(); k++) begin
      n_cmp++;
      if (gap_q[k] != GC) begin
        n_err++;
        $display("FAIL bp_gap_len idx=%0d: got %0d expected %0d", k - gb, gap_q[k], GC);
      end
    end
    n_cmp++;
    if (done_cnt - db != 1) begin
      n_err++;
      $display("FAIL bp_done: got %0d expected 1", done_cnt - db);
    end
  endtask

  task automatic test_async_reset();
    bit tmo, acc_ok;
    int db;
    msg[0] = 8'($urandom);
    db = done_cnt;
    drive_msg(1, 1, -1, 0, tmo, acc_ok);
    @(posedge clk); #1;
    n_cmp++;
    if (tmo || busy !== 1'b1 || load !== 1'b0) begin
      n_err++;
      $display("FAIL rst_pre_gap: got tmo=%0d busy=%b load=%b expected 0 1 0", tmo, busy, load);
    end
    #3 rst_p = 1'b1;
    #1;
    n_cmp++;
    if ({load, start, in_en, busy, done, s_ready} !== 6'b0) begin
      n_err++;
      $display("FAIL rst_async_ctrl: got %b expected 000000", {load, start, in_en, busy, done, s_ready});
    end
    n_cmp++;
    if (part_msg !== 8'h00) begin
      n_err++;
      $display("FAIL rst_async_part_msg: got %h expected 00", part_msg);
    end
    @(posedge clk); #1;
    rst_p = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_release_ready: got s_ready=%b busy=%b expected 1 0", s_ready, busy);
    end
    n_cmp++;
    if (done_cnt != db) begin
      n_err++;
      $display("FAIL rst_no_done: got %0d pulses expected 0", done_cnt - db);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    logic [7:0] exp_q[$];
    int cb, db, t, acc_b, d_at_b, dcyc_b, nbad;
    bit rdy1, rdy2, tmo;
    a = 8'($urandom); b = 8'($urandom);
    exp_q.delete();
    exp_q.push_back(a); exp_q.push_back(8'h80);
    while (exp_q.size() < BB) exp_q.push_back(8'h00);
    exp_q.push_back(b); exp_q.push_back(8'h80);
    while (exp_q.size() < 2 * BB) exp_q.push_back(8'h00);
    cb = cap_q.size(); db = done_cnt;
    s_data = a; s_last = 1'b1; s_valid = 1'b1;
    t = 0;
    do begin
      rdy1 = (s_ready === 1'b1);
      @(posedge clk); #1;
      t++;
    end while (!rdy1 && t < 100);
    s_data = b;
    t = 0;
    do begin
      rdy2 = (s_ready === 1'b1);
      @(posedge clk); #1;
      t++;
    end while (!rdy2 && t < 3000);
    acc_b = cyc; d_at_b = done_cnt; dcyc_b = done_cyc;
    s_valid = 1'b0; s_last = 1'b0;
    wait_done(tmo);
    n_cmp++;
    if (!rdy1 || !rdy2 || tmo) begin
      n_err++;
      $display("FAIL b2b_timeout: got acc1=%0d acc2=%0d done_tmo=%0d expected 1 1 0", rdy1, rdy2, tmo);
    end
    n_cmp++;
    if (d_at_b - db != 1 || acc_b <= dcyc_b) begin
      n_err++;
      $display("FAIL b2b_accept_after_done: got dones=%0d accept_cyc=%0d done_cyc=%0d expected 1 and later", d_at_b - db, acc_b, dcyc_b);
    end
    n_cmp++;
    if (cap_q.size() - cb != 2 * BB) begin
      n_err++;
      $display("FAIL b2b_count: got %0d expected %0d", cap_q.size() - cb, 2 * BB);
    end
    n_cmp++;
    if (cap_q.size() > cb + BB + 1 && cap_q[cb + BB + 1] !== 8'h80) begin
      n_err++;
      $display("FAIL b2b_second_pad_pos: got %h expected 80", cap_q[cb + BB + 1]);
    end
    nbad = 0;
    for (int k = 0; k < 2 * BB; k++) begin
      logic [7:0] got;
      got = (cb + k < cap_q.size()) ? cap_q[cb + k] : 8'hxx;
      if (got !== exp_q[k]) nbad++;
    end
    n_cmp++;
    if (nbad != 0) begin
      n_err++;
      $display("FAIL b2b_bytes: got %0d wrong bytes expected 0", nbad);
    end
    n_cmp++;
    if (done_cnt - db != 2) begin
      n_err++;
      $display("FAIL b2b_done: got %0d expected 2", done_cnt - db);
    end
  endtask

  task automatic test_abort();
    int cb, db, t, nbad;
    bit tmo, acc_ok, tmo2;
    logic [7:0] exp_q[$];
    for (int i = 0; i < 20; i++) msg[i] = 8'($urandom);
    cb = cap_q.size(); db = done_cnt;
    drive_msg(20, 10, -1, 0, tmo, acc_ok);
    t = 0;
    while (load !== 1'b1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    n_cmp++;
    if (tmo || load !== 1'b1) begin
      n_err++;
      $display("FAIL abort_reach_load: got tmo=%0d load=%b expected 0 1", tmo, load);
    end
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++;
    if ({load, start, in_en, busy, s_ready} !== 5'b0) begin
      n_err++;
      $display("FAIL abort_outputs: got %b expected 00000", {load, start, in_en, busy, s_ready});
    end
    n_cmp++;
    if (part_msg !== 8'h00) begin
      n_err++;
      $display("FAIL abort_part_msg: got %h expected 00", part_msg);
    end
    n_cmp++;
    if (cap_q.size() - cb != 10) begin
      n_err++;
      $display("FAIL abort_bytes_before: got %0d expected 10", cap_q.size() - cb);
    end
    repeat (300) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt != db || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_done: got dones=%0d busy=%b expected 0 0", done_cnt - db, busy);
    end

    for (int i = 0; i < 3; i++) msg[i] = 8'($urandom);
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(msg[i]);
    exp_q.push_back(8'h80);
    while (exp_q.size() % BB != 0) exp_q.push_back(8'h00);
    cb = cap_q.size(); db = done_cnt;
    drive_msg(3, 3, -1, 0, tmo, acc_ok);
    wait_done(tmo2);
    n_cmp++;
    if (tmo || tmo2 || cap_q.size() - cb != BB) begin
      n_err++;
      $display("FAIL abort_next_count: got %0d bytes tmo=%0d/%0d expected %0d", cap_q.size() - cb, tmo, tmo2, BB);
    end
    nbad = 0;
    for (int k = 0; k < BB; k++) begin
      logic [7:0] got;
      got = (cb + k < cap_q.size()) ? cap_q[cb + k] : 8'hxx;
      if (got !== exp_q[k]) nbad++;
    end
    n_cmp++;
    if (nbad != 0) begin
      n_err++;
      $display("FAIL abort_next_bytes: got %0d wrong bytes expected 0", nbad);
    end
    n_cmp++;
    if (done_cnt - db != 1) begin
      n_err++;
      $display("FAIL abort_next_done: got %0d expected 1", done_cnt - db);
    end

    // abort and a valid byte in the same FETCH cycle: abort must win
    msg[0] = 8'($urandom); msg[1] = 8'($urandom);
    cb = cap_q.size(); db = done_cnt;
    drive_msg(2, 1, -1, 0, tmo, acc_ok);
    t = 0;
    while (s_ready !== 1'b1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    s_data = msg[1]; s_last = 1'b1; s_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; abort = 1'b0;
    n_cmp++;
    if (tmo || busy !== 1'b0 || start !== 1'b0 || s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL abort_vs_accept: got tmo=%0d busy=%b start=%b s_ready=%b expected 0 0 0 0", tmo, busy, start, s_ready);
    end
    repeat (60) @(posedge clk);
    #1;
    n_cmp++;
    if (cap_q.size() - cb != 1 || done_cnt != db) begin
      n_err++;
      $display("FAIL abort_vs_accept_quiet: got bytes=%0d dones=%0d expected 1 0", cap_q.size() - cb, done_cnt - db);
    end
  endtask

  initial begin
    test_reset();
    test_padding();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of run expected finish before 900000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cubehash_msg_tx.md
Name: cubehash_msg_tx

Overview:
- Byte-serial message transmitter that feeds the cubehash_exp core's message-load interface: `part_msg`, `load`, `start` and `in_en`.
- Accepts a message byte stream from an upstream valid/ready source.
- Applies CubeHash padding: append 0x80, then zero-fill to the block boundary.
- Drives each byte with the core's level-held load strobe and inter-byte gap timing.
- Sits between the system message buffer and cubehash_exp.

Parameters:
- BLOCK_BYTES, 32, message block size in bytes; must be a power of 2.
- LOAD_CYCLES, 10, cycles `load` is held high per byte.
- GAP_CYCLES, 12, minimum cycles `load` is low before each byte's load; `part_msg` is stable throughout the gap.
- TAIL_CYCLES, 250, cycles `start` stays high after the final byte's load, giving the core time for final rounds.

Ports:
- clk  in  1  system clock, rising edge.
- rst_p  in  1  asynchronous, active-high reset.
- s_data  in  8  upstream message byte.
- s_valid  in  1  upstream byte valid.
- s_last  in  1  `s_data` is the final message byte; every message is at least 1 byte.
- s_ready  out  1  transmitter accepts the byte this cycle.
- abort  in  1  synchronous abort of the current message.
- part_msg  out  8  byte presented to the core.
- load  out  1  byte-load strobe to the core.
- start  out  1  hash-session active to the core.
- in_en  out  1  input enable to the core.
- busy  out  1  message in progress.
- done  out  1  one-cycle pulse when the session ends.

Behaviour:
- Reset (async, rst_p=1): state IDLE; all outputs 0, including `part_msg`=8'h00 and `s_ready`=0 during reset; position counter `pos`=0; timers 0.
- Handshake: a byte is accepted iff `s_valid` && `s_ready`. `s_ready`=1 only in IDLE and FETCH. `s_valid` in other states is ignored with no side effect.

State machine:
- IDLE
  - `start`=`in_en`=`busy`=0; `pos`=0.
  - On accept: `part_msg`<=`s_data`, `last_q`<=`s_last`, `start`/`in_en`/`busy`<=1, go to GAP.
- GAP
  - `load`=0 for GAP_CYCLES, then go to LOAD with `load`<=1.
- LOAD
  - `load`=1 for LOAD_CYCLES.
  - On the final cycle: `load`<=0 and `pos`<=`pos`+1 mod BLOCK_BYTES (wraps to 0).
  - Next state:
    - data byte with `last_q`=0 -> FETCH;
    - data byte with `last_q`=1 -> GAP with `part_msg`<=8'h80 and pad flag set;
    - pad byte with new `pos`!=0 -> GAP with `part_msg`<=8'h00;
    - pad byte with new `pos`==0 -> TAIL.
- FETCH
  - `s_ready`=1, `load`=0.
  - On accept: capture the byte as in IDLE, then go to GAP.
  - Upstream stall lengthens the gap; no padding is inserted on a stall.
- TAIL
  - `start`=`in_en`=1, `load`=0 for TAIL_CYCLES.
  - Then `start`/`in_en`/`busy`<=0, `done`=1 for one cycle, go to IDLE.

Padding and timing:
- Padding rule: after the last data byte, emit 0x80 then zeros until `pos` wraps to 0.
- A message whose length is a multiple of BLOCK_BYTES gets a full extra block: 0x80 followed by BLOCK_BYTES-1 zeros.
- Total bytes sent = (floor(L/BLOCK_BYTES)+1)*BLOCK_BYTES.
- `part_msg` changes only on entry to GAP, never while `load`=1.
- Per-byte period without stall = GAP_CYCLES+LOAD_CYCLES.

Abort and reset:
- `abort` in any non-IDLE state: next cycle all outputs 0, `pos`=0, IDLE, no `done` pulse.
- `abort` has priority over a simultaneous accept. `abort` in IDLE is ignored.
- Reset mid-operation: same result as `abort`, applied immediately.

Widths:
- `pos` is clog2(BLOCK_BYTES) bits.
- A single shared down-counter timer is clog2(max(LOAD_CYCLES,GAP_CYCLES,TAIL_CYCLES)+1) bits, reloaded on every state entry.

Decomposition:
- Package cubehash_tx_pkg holds:
  - state enum {IDLE, GAP, LOAD, FETCH, TAIL};
  - PAD_FIRST=8'h80 and PAD_FILL=8'h00;
  - default timing constants.
- One sub-module, cubehash_tx_timer: loadable down-counter with a load value input and a zero flag, used for the GAP, LOAD and TAIL durations.

Test Plan:
- 3-byte message 00,00,00 (`s_last` on byte 3):
  - exactly 32 load pulses, each 10 cycles high with 12-cycle gaps;
  - the 4th byte is 0x80 and bytes 5..32 are 0x00;
  - `start` is high from accept through the end of the last load plus 250 cycles;
  - `done` pulses once.
- 31-byte message: 32 loads and the 32nd byte is 0x80. 32-byte message: 64 loads, byte 33 is 0x80 and bytes 34..64 are 0x00.
- Backpressure: deassert `s_valid` for 50 cycles after byte 2 of a 5-byte message:
  - `load` stays low for the whole stall;
  - no extra bytes are sent;
  - the padded total is still 32.
- Two 1-byte messages back-to-back, `s_valid` held: the second is accepted only after `done`, and its 0x80 is again at byte position 2 (`pos` restarted at 0).
- `abort` during the LOAD of byte 10: next cycle `load`/`start`/`in_en`/`busy`=0, no `done`; a subsequent message starts at `pos` 0.
- `rst_p` pulse mid-GAP: outputs clear asynchronously before the next clock edge; after release, `s_ready`=1 in IDLE.
